// File: rtl/bcd2bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd2bin : sequential BCD-to-binary decoder, one digit per clock (Horner) |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module bcd2bin #(
  parameter int Digits   = 4,
  parameter int BinWidth = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*Digits-1:0]   bcd_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [BinWidth-1:0]   bin_o,
  output logic                  error_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [63:0]        c_RANGE     = 64'd10 ** Digits;
  localparam int                 c_MIN_WIDTH = $clog2(c_RANGE);
  localparam int                 c_CNT_W     = $clog2(Digits + 1);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(Digits - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CONV = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  generate
    if (BinWidth < c_MIN_WIDTH) begin : g_width_check
      $error("bcd2bin: BinWidth too small to hold 10**Digits - 1");
    end
  endgenerate

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [4*Digits-1:0]   r_sr;
  logic [BinWidth-1:0]   r_acc;
  logic [BinWidth-1:0]   w_acc_next;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [BinWidth-1:0]   r_bin;
  logic                  r_err;
  logic                  w_bad;
  logic                  w_accept;
  logic                  w_step;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (valid_i)         w_state_next = c_CONV;
      c_CONV:  if (r_cnt == c_LAST) w_state_next = c_DONE;
      c_DONE:  if (ready_i)         w_state_next = c_IDLE;
      default:                      w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (r_state == c_IDLE);
    valid_o = (r_state == c_DONE);
  end

  assign w_accept   = valid_i && (r_state == c_IDLE);
  assign w_step     = (r_state == c_CONV);
  // acc*10 as (acc<<3)+(acc<<1), then add the digit now at the top of the shifter
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BinWidth'(r_sr[4*Digits-1 -: 4]);

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < Digits; i++) begin
      if (bcd_i[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sr  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_bin <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_sr  <= bcd_i;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= w_bad;
    end else if (w_step) begin
      r_sr  <= r_sr << 4;
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + c_CNT_W'(1);
      // result register only moves on the final digit so it holds between results
      if (r_cnt == c_LAST) r_bin <= r_err ? '0 : w_acc_next;
    end
  end

  assign bin_o   = r_bin;
  assign error_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin.sv
`default_nettype none
// Testbench for bcd2bin: directed vectors plus an exhaustive legal sweep with random stalls,
// checked every cycle against a place-value reference model.
module tb_bcd2bin;

  localparam int DIG = 4;
  localparam int BW  = 14;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [15:0]   bcd_i;
  logic          valid_i;
  logic          ready_o;
  logic [BW-1:0] bin_o;
  logic          error_o;
  logic          valid_o;
  logic          ready_i;

  bcd2bin #(.Digits(DIG), .BinWidth(BW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bcd_i   (bcd_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .bin_o   (bin_o),
    .error_o (error_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of digit * 10^position; any nibble above 9 forces result 0 with flag.
  function automatic void ref_model(input logic [15:0] b, output int v, output bit e);
    int p;
    v = 0; e = 1'b0; p = 1;
    for (int i = 0; i < DIG; i++) begin
      int d;
      d = int'(b[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v += d * p;
      p *= 10;
    end
    if (e) v = 0;
  endfunction

  typedef struct {int bin; bit err;} res_t;
  res_t m_q[$];
  bit   m_known    = 1'b0;
  bit   m_busy     = 1'b0;
  int   m_edges    = 0;
  int   m_last_bin = 0;
  bit   m_last_err = 1'b0;
  int   m_accepts  = 0;
  int   m_xfers    = 0;
  int   m_aborts   = 0;
  int   sends      = 0;
  bit   rnd_rdy    = 1'b0;

  // Per-cycle compare: inputs and outputs are both stable at the falling edge.
  always @(negedge clk_i) begin : compare
    bit   exp_valid;
    res_t r;
    exp_valid = m_busy && (m_edges >= DIG);
    if (m_known) begin
      chk("ready_o", 32'(ready_o), 32'(!m_busy));
      chk("valid_o", 32'(valid_o), 32'(exp_valid));
      if (exp_valid) begin
        chk("bin_o", 32'(bin_o), 32'(m_q[0].bin));
        chk("error_o", 32'(error_o), 32'(m_q[0].err));
      end else begin
        chk("bin_o hold", 32'(bin_o), 32'(m_last_bin));
      end
      if (!m_busy) chk("error_o hold", 32'(error_o), 32'(m_last_err));
    end
    if (rst_i) begin
      if (m_busy) begin
        m_aborts++;
        void'(m_q.pop_front());
      end
      m_busy = 1'b0; m_last_bin = 0; m_last_err = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_busy) begin
        if (exp_valid && ready_i) begin
          m_xfers++;
          m_last_bin = m_q[0].bin;
          m_last_err = m_q[0].err;
          void'(m_q.pop_front());
          m_busy = 1'b0;
        end else if (!exp_valid) begin
          m_edges++;
        end
      end else if (valid_i) begin
        ref_model(bcd_i, r.bin, r.err);
        m_q.push_back(r);
        m_busy = 1'b1; m_edges = 0; m_accepts++;
      end
    end
  end

  always @(posedge clk_i) begin
    if (rnd_rdy) begin
      #1 ready_i = ($urandom_range(7) != 0);
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [15:0] b);
    bit a;
    bit ok;
    ok = 1'b0;
    valid_i = 1'b1;
    bcd_i   = b;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_i);
      a = (ready_o === 1'b1);
      @(posedge clk_i);
      #1;
      if (a) begin
        ok = 1'b1;
        break;
      end
    end
    valid_i = 1'b0;
    if (ok) sends++;
    else chk("accept timeout", 32'(ready_o), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) return;
      lat++;
    end
    chk("valid_o timeout", 32'(valid_o), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] b, input int eb, input bit ee, input string tag);
    int lat;
    send(b);
    wait_valid(lat);
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " bin"}, 32'(bin_o), 32'(eb));
    chk({tag, " err"}, 32'(error_o), 32'(ee));
    @(negedge clk_i);
    chk({tag, " ready back"}, 32'(ready_o), 32'd1);
    chk({tag, " valid drop"}, 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [15:0] b;
    int          idx;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; bcd_i = 16'h0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset ready_o", 32'(ready_o), 32'd1);
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset bin_o", 32'(bin_o), 32'd0);
    chk("reset error_o", 32'(error_o), 32'd0);
    @(posedge clk_i);
    #1;

    run_op(16'h1234, 1234, 1'b0, "op1234");
    run_op(16'h0000, 0,    1'b0, "op0000");
    run_op(16'h9999, 9999, 1'b0, "op9999");
    run_op(16'h0001, 1,    1'b0, "op0001");
    run_op(16'h12A4, 0,    1'b1, "op12A4");
    run_op(16'hF000, 0,    1'b1, "opF000");
    run_op(16'h0042, 42,   1'b0, "op0042");

    // Backpressure: result held while a new operand waits upstream.
    ready_i = 1'b0;
    send(16'h0987);
    wait_valid(lat);
    chk("bp latency", 32'(lat), 32'd4);
    @(posedge clk_i);
    #1;
    valid_i = 1'b1;
    bcd_i   = 16'h5555;
    repeat (5) begin
      @(negedge clk_i);
      chk("bp valid_o", 32'(valid_o), 32'd1);
      chk("bp bin_o", 32'(bin_o), 32'd987);
      chk("bp ready_o", 32'(ready_o), 32'd0);
    end
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    send(16'h5555);
    wait_valid(lat);
    chk("op5555 bin", 32'(bin_o), 32'd5555);
    chk("op5555 err", 32'(error_o), 32'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;

    // Reset sampled at the second edge after acceptance.
    send(16'h4321);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort ready_o", 32'(ready_o), 32'd1);
    chk("abort valid_o", 32'(valid_o), 32'd0);
    chk("abort bin_o", 32'(bin_o), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) seen++;
    end
    chk("abort no result", 32'(seen), 32'd0);
    @(posedge clk_i);
    #1;

    // Every legal operand, sprinkled with illegal ones, under random stalls.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(7) == 0) begin
        @(posedge clk_i);
        #1;
      end
      send({4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)});
      if (n % 40 == 0) begin
        b   = 16'($urandom);
        idx = int'($urandom_range(3));
        b[idx*4 +: 4] = 4'(10 + $urandom_range(5));
        send(b);
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk_i);
    #2 ready_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;

    chk("accepted == sent", 32'(m_accepts), 32'(sends));
    chk("no lost or duplicated", 32'(m_xfers + m_aborts), 32'(m_accepts));
    chk("one abort", 32'(m_aborts), 32'd1);
    chk("nothing in flight", 32'(m_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd2bin.md
# bcd2bin

Sequential multi-digit BCD-to-binary decoder. Accepts a packed BCD word (`Digits` nibbles, most significant digit in the top nibble) over a valid/ready handshake. Converts it by Horner iteration, one digit per clock: acc = acc·10 + digit. Presents the binary result with an invalid-digit flag over a second valid/ready handshake. It is the decode-side counterpart of the binary-to-BCD encoder and sits between BCD-formatted sources (keypads, display buffers, counters) and binary arithmetic.

## Interface
Parameters:
- `Digits`, 4, number of BCD digits in `bcd_i` (≥ 1)
- `BinWidth`, 14, width of `bin_o`; must be ≥ ceil(log2(10^Digits)); elaboration fails otherwise

Ports:
- `clk_i`  input  1  single clock; all state updates on the rising edge
- `rst_i`  input  1  synchronous, active-high reset
- `bcd_i`  input  4·Digits  packed BCD operand; nibble `Digits-1` is the MSD
- `valid_i`  input  1  upstream offers `bcd_i`
- `ready_o`  output  1  block can accept an operand
- `bin_o`  output  BinWidth  binary result; held stable while `valid_o` is high
- `error_o`  output  1  result flag: at least one input nibble was > 9
- `valid_o`  output  1  `bin_o`/`error_o` are valid
- `ready_i`  input  1  downstream accepts the result

## Operation
- State machine with states IDLE, CONV and DONE.
- IDLE: `ready_o`=1, `valid_o`=0.
  - On `valid_i`&`ready_o`: capture `bcd_i` into the digit shift register, clear the accumulator and digit counter, and compute `error_o` from the captured nibbles (any nibble ≥ 0xA).
  - Then go to CONV.
- CONV: `ready_o`=0, `valid_o`=0. Each cycle:
  - acc ← (acc<<3) + (acc<<1) + top nibble.
  - Shift the digit register left by 4 and increment the counter.
  - After `Digits` iterations, go to DONE.
- DONE: `valid_o`=1.
  - `bin_o` = acc if `error_o`=0, otherwise `bin_o` = 0.
  - On `valid_o`&`ready_i`, go to IDLE.
- Arithmetic is unsigned, at BinWidth bits. With a legal `BinWidth` and valid digits, no overflow is possible.
  - With invalid nibbles the accumulator may wrap modulo 2^BinWidth; this is irrelevant because `bin_o` is forced to 0.
- `valid_i` and `bcd_i` are ignored outside IDLE. The upstream must hold the operand until accepted.
- There is no same-cycle bypass: DONE→IDLE and IDLE→CONV never happen on the same edge.
- `error_o` and `bin_o` are only meaningful while `valid_o`=1. Between results they hold their last values.

## Timing
- Reset (`rst_i`=1 at an edge): state=IDLE, `ready_o`=1, `valid_o`=0, `bin_o`=0, `error_o`=0, accumulator and counter cleared.
- Reset has priority over every other event, including a handshake on the same edge.
- Reset mid-CONV or mid-DONE aborts the conversion; no result is emitted.
- Latency: acceptance at edge E0. Digits are processed at edges E1..E`Digits`. `valid_o` rises at edge E`Digits`, i.e. it is first high in the cycle after E`Digits`.
- Output handshake: `valid_o` stays high, and `bin_o`/`error_o` stay stable, until an edge with `ready_i`=1. `ready_o` rises at that same edge.
- Minimum period per operand: `Digits`+2 cycles (6 for default parameters).
- `ready_o` and `valid_o` are decoded from registered state only; there is no combinational path from `valid_i`/`ready_i`.

## Test plan
- Reset, then `bcd_i`=0x1234 with `valid_i`=1 and `ready_i`=1 → `bin_o`=0x04D2 (1234), `error_o`=0; `valid_o` first high 4 cycles after the accept edge; `ready_o` high again 1 cycle later.
- Boundaries: 0x0000 → 0x0000; 0x9999 → 0x270F (9999); 0x0001 → 0x0001. All with `error_o`=0.
- Invalid digit: 0x12A4 → `bin_o`=0, `error_o`=1. Then 0xF000 → `bin_o`=0, `error_o`=1. Next operand 0x0042 → `bin_o`=42, `error_o`=0 (no flag stickiness).
- Backpressure: complete 0x0987 with `ready_i`=0 for 5 cycles → `valid_o`=1 and `bin_o`=987 held stable throughout, `ready_o`=0. Meanwhile `valid_i`=1 with 0x5555 is not accepted. After `ready_i`=1, 0x5555 is accepted and yields 5555.
- Reset mid-CONV: accept 0x4321, assert `rst_i` at edge E2 → next cycle `ready_o`=1, `valid_o`=0, `bin_o`=0; no result for 0x4321 ever appears.
- Exhaustive/random: all 10000 legal 4-digit operands plus random illegal nibbles, with random `valid_i`/`ready_i` stalls. Check against a reference model; check result ordering, and that there are no lost or duplicated transfers.
